dmem_lsu_port: RTL and testbench
================================

# dmem_lsu_port

Parametrised data memory for the out-of-order core: one load port and one store port, both using a valid/ready handshake. It adds byte-enable stores, a configurable read latency and tagged load responses, so loads can complete out of order relative to the issuing queue. A flush squashes in-flight loads after a mispredict, and an optional clear-on-reset sequencer zeroes the array. It sits between the load/store queue and the memory array.

## Interface
- DATA_W, 16: data width; must be a multiple of 8.
- ADDR_W, 16: address width; depth is 2**ADDR_W words, word-addressed.
- TAG_W, 4: load tag width.
- RD_LAT, 1: load latency in cycles; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents untouched by reset.
- Derived: BE_W = DATA_W/8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_req_valid  in  1  load request present.
- ld_req_ready  out  1  load request accepted when valid && ready.
- ld_req_addr  in  ADDR_W  load word address.
- ld_req_tag  in  TAG_W  tag echoed on the response.
- ld_rsp_valid  out  1  load response valid; single cycle, no backpressure.
- ld_rsp_data  out  DATA_W  load data.
- ld_rsp_tag  out  TAG_W  tag of the returning load.
- st_req_valid  in  1  store request present.
- st_req_ready  out  1  store accepted when valid && ready.
- st_req_addr  in  ADDR_W  store word address.
- st_req_data  in  DATA_W  store data.
- st_req_be  in  BE_W  byte enables; bit i covers data[8i+7:8i].
- flush  in  1  squash all in-flight and same-cycle loads.
- busy  out  1  high while the clear sequence runs.

## Operation
FSM states:
- CLEAR (entered on rst when CLEAR_ON_RESET=1):
  - Writes zero to address clr_ptr each cycle; clr_ptr runs 0 to 2**ADDR_W-1.
  - busy=1; ld_req_ready=st_req_ready=0.
  - After the last address, moves to RUN.
- RUN (entered directly on rst when CLEAR_ON_RESET=0):
  - busy=0; both readies are 1 every cycle.

Rules in RUN:
- Store: the accepted store updates only the bytes whose st_req_be bit is 1. be=0 is a legal no-op.
- Load: the accepted load enters a RD_LAT-deep valid/tag/data pipeline.
- Same-cycle load and store to the same address: the load returns the post-store word (write-first), merged per byte.
- flush=1: clears the valid bit of every pipeline stage and drops any load accepted in the same cycle.
  - Stores are never squashed.
  - A store accepted in the flush cycle still commits.
- Addresses are always in range, because depth is 2**ADDR_W; no wrap handling is needed.

Reset:
- Reset values: ld_rsp_valid=0, ld_rsp_data=0, ld_rsp_tag=0, all pipeline valids=0, clr_ptr=0.
- After rst: busy=1 if CLEAR_ON_RESET=1, otherwise busy=0.
- rst asserted mid-CLEAR restarts CLEAR at address 0.
- rst asserted in RUN drops all in-flight loads.

## Timing
- Load accepted at edge T: ld_rsp_valid, data and tag are presented in the cycle after edge T+RD_LAT-1. With RD_LAT=1 the response appears in the cycle following acceptance.
- Responses leave in acceptance order and are spaced exactly as accepted; throughput is 1 load + 1 store per cycle.
- Store accepted at T: visible to any load accepted at T or later.
- A load already in flight does not see a later store.
- ld_rsp_data is 0 in any cycle where ld_rsp_valid=0.
- CLEAR takes exactly 2**ADDR_W cycles from rst deassertion to busy=0.
- Readies first go high in the cycle busy falls.

## Structure
- Shared package dmem_pkg holds:
  - the FSM state enum (CLEAR, RUN);
  - the byte-merge function (old word, new word, be) -> merged word, reused for both the array write and the forwarding path.
- One sub-module, dmem_rd_pipe: a RD_LAT-stage valid/tag/data shift register with synchronous flush.
- Array, FSM and forwarding logic live in the top level.

## Test plan
- Clear sequence: ADDR_W=4, CLEAR_ON_RESET=1, rst for 1 cycle.
  - busy stays high for exactly 16 cycles, readies low throughout.
  - Loads of addresses 0..15 afterwards all return 0.
- Byte enable: store 0xABCD to addr 5 with be=2'b11, then 0x1200 with be=2'b10.
  - Load addr 5 returns 0x12CD with its tag.
- Write-first collision: in the same cycle, store 0x5A5A to addr 3 (be=2'b11) and load addr 3 with tag 7.
  - Response is 0x5A5A, tag 7, RD_LAT cycles later, for RD_LAT=1 and RD_LAT=3.
- Flush: RD_LAT=3; back-to-back loads tagged 1, 2, 3; flush in the cycle load 3 is accepted.
  - No ld_rsp_valid is produced for any of them.
  - A load tagged 4 issued the next cycle responds normally.
- Reset mid-clear: rst reasserted at clr_ptr=9.
  - Clearing restarts at 0; busy lasts a full 2**ADDR_W cycles after the second rst.
- Streaming: 64 random loads and stores at 1 of each per cycle, checked against a reference model.
  - Data and tags match in order with zero bubbles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the LSU-facing data memory.
// The byte-merge helper is sized for the widest supported word.
package dmem_pkg;

  typedef enum logic {CLEAR, RUN} dmem_state_e;

  localparam int MERGE_MAX_W  = 64;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  // Used for both the array write and the same-cycle forwarding path.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_lsu_port_rd_pipe.sv
// Fixed-latency valid/tag/data shift register for load responses.
// Flush kills every stage, including the entry being written this cycle.
module dmem_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q [DEPTH];
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid && !flush;
      tag_q[0]   <= in_tag;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1] && !flush;
        tag_q[i]   <= tag_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Data is forced to zero whenever no response is being presented.
  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
  assign out_data  = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/dmem_lsu_port.sv
// Data memory with one load and one store port, tagged fixed-latency loads,
// write-first forwarding, flush of in-flight loads and an optional clear sequencer.
module dmem_lsu_port
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int TAG_W          = 4,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_W          = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [ADDR_W-1:0] ld_req_addr,
  input  logic [TAG_W-1:0]  ld_req_tag,
  output logic              ld_rsp_valid,
  output logic [DATA_W-1:0] ld_rsp_data,
  output logic [TAG_W-1:0]  ld_rsp_tag,
  input  logic              st_req_valid,
  output logic              st_req_ready,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [DATA_W-1:0] st_req_data,
  input  logic [BE_W-1:0]   st_req_be,
  input  logic              flush,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam dmem_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  dmem_state_e       state;
  dmem_state_e       state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run_en;
  logic              clear_we;
  logic              ld_fire;
  logic              st_fire;
  logic              fwd_hit;
  logic [DATA_W-1:0] st_merged;
  logic [DATA_W-1:0] ld_data;

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (clr_ptr == '1) state_next = RUN;
      RUN:   state_next = RUN;
    endcase
  end

  // Nothing is accepted while rst is high, so requests never race the reset.
  always_comb begin
    busy         = (state == CLEAR);
    run_en       = (state == RUN) && !rst;
    clear_we     = (state == CLEAR) && !rst;
    ld_req_ready = run_en;
    st_req_ready = run_en;
  end

  always_ff @(posedge clk) begin
    if (rst)           clr_ptr <= '0;
    else if (clear_we) clr_ptr <= clr_ptr + ADDR_W'(1);
  end

  assign ld_fire = ld_req_valid && ld_req_ready;
  assign st_fire = st_req_valid && st_req_ready;

  assign st_merged = DATA_W'(byte_merge(MERGE_MAX_W'(mem[st_req_addr]),
                                        MERGE_MAX_W'(st_req_data),
                                        MERGE_MAX_BE'(st_req_be)));

  // Write-first: a same-cycle store to the load address is forwarded byte-merged.
  assign fwd_hit = st_fire && (st_req_addr == ld_req_addr);
  assign ld_data = fwd_hit ? st_merged : mem[ld_req_addr];

  always_ff @(posedge clk) begin
    if (clear_we)     mem[clr_ptr]     <= '0;
    else if (st_fire) mem[st_req_addr] <= st_merged;
  end

  dmem_rd_pipe #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (ld_fire),
    .in_tag    (ld_req_tag),
    .in_data   (ld_data),
    .out_valid (ld_rsp_valid),
    .out_tag   (ld_rsp_tag),
    .out_data  (ld_rsp_data)
  );

endmodule

// File: tb/tb_dmem_lsu_port.sv
// Bench for dmem_lsu_port: two instances (RD_LAT=1 and RD_LAT=3) share stimulus
// and are compared every cycle against a cycle-indexed expected-response model.
module tb_dmem_lsu_port;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int TAG_W  = 4;
  localparam int BE_W   = 2;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_req_valid = 1'b0;
  logic [ADDR_W-1:0] ld_req_addr = '0;
  logic [TAG_W-1:0]  ld_req_tag = '0;
  logic              st_req_valid = 1'b0;
  logic [ADDR_W-1:0] st_req_addr = '0;
  logic [DATA_W-1:0] st_req_data = '0;
  logic [BE_W-1:0]   st_req_be = '0;
  logic              flush = 1'b0;

  logic              ld_req_ready_l1, st_req_ready_l1, ld_rsp_valid_l1, busy_l1;
  logic [DATA_W-1:0] ld_rsp_data_l1;
  logic [TAG_W-1:0]  ld_rsp_tag_l1;
  logic              ld_req_ready_l3, st_req_ready_l3, ld_rsp_valid_l3, busy_l3;
  logic [DATA_W-1:0] ld_rsp_data_l3;
  logic [TAG_W-1:0]  ld_rsp_tag_l3;

  dmem_lsu_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready_l1), .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
    .ld_rsp_valid(ld_rsp_valid_l1), .ld_rsp_data(ld_rsp_data_l1), .ld_rsp_tag(ld_rsp_tag_l1),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready_l1), .st_req_addr(st_req_addr),
    .st_req_data(st_req_data), .st_req_be(st_req_be), .flush(flush), .busy(busy_l1)
  );

  dmem_lsu_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .RD_LAT(3), .CLEAR_ON_RESET(1)) dut_l3 (
    .clk(clk), .rst(rst),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready_l3), .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
    .ld_rsp_valid(ld_rsp_valid_l3), .ld_rsp_data(ld_rsp_data_l3), .ld_rsp_tag(ld_rsp_tag_l3),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready_l3), .st_req_addr(st_req_addr),
    .st_req_data(st_req_data), .st_req_be(st_req_be), .flush(flush), .busy(busy_l3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 1'b0;
  int clr_left = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_data_l1 [int];
  logic [TAG_W-1:0]  exp_tag_l1  [int];
  logic [DATA_W-1:0] exp_data_l3 [int];
  logic [TAG_W-1:0]  exp_tag_l3  [int];

  int                rsp_cnt_l1 = 0, rsp_cnt_l3 = 0;
  int                last_cyc_l1 = 0, last_cyc_l3 = 0;
  logic [DATA_W-1:0] last_data_l1 = '0, last_data_l3 = '0;
  logic [TAG_W-1:0]  last_tag_l1 = '0, last_tag_l3 = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    if (be[0]) r[7:0]  = new_w[7:0];
    if (be[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  task automatic dropFrom(input int first);
    for (int k = first; k < first + 4; k++) begin
      if (exp_tag_l1.exists(k)) begin exp_tag_l1.delete(k); exp_data_l1.delete(k); end
      if (exp_tag_l3.exists(k)) begin exp_tag_l3.delete(k); exp_data_l3.delete(k); end
    end
  endtask

  // Reference model: a response to a load accepted at edge n is due in the
  // cycle after edge n+RD_LAT-1; reset and flush cancel anything not yet shown.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        started  = 1'b1;
        clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        dropFrom(cyc);
      end else if (started) begin
        if (clr_left > 0) begin
          clr_left--;
        end else begin
          if (flush) dropFrom(cyc);
          if (st_req_valid) model_mem[st_req_addr] = mergeBytes(model_mem[st_req_addr], st_req_data, st_req_be);
          if (ld_req_valid && !flush) begin
            exp_data_l1[cyc]     = model_mem[ld_req_addr];
            exp_tag_l1[cyc]      = ld_req_tag;
            exp_data_l3[cyc + 2] = model_mem[ld_req_addr];
            exp_tag_l3[cyc + 2]  = ld_req_tag;
          end
        end
      end
    end
  end

  // Compare process, sampling on the falling edge.
  initial begin
    bit exp_busy;
    bit v;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_busy = (clr_left > 0);
        checkOutput("busy_l1", 32'(busy_l1), 32'(exp_busy));
        checkOutput("busy_l3", 32'(busy_l3), 32'(exp_busy));
        if (!rst) begin
          checkOutput("ld_ready_l1", 32'(ld_req_ready_l1), 32'(!exp_busy));
          checkOutput("st_ready_l1", 32'(st_req_ready_l1), 32'(!exp_busy));
          checkOutput("ld_ready_l3", 32'(ld_req_ready_l3), 32'(!exp_busy));
          checkOutput("st_ready_l3", 32'(st_req_ready_l3), 32'(!exp_busy));
        end
        v = exp_tag_l1.exists(cyc);
        checkOutput("rsp_valid_l1", 32'(ld_rsp_valid_l1), 32'(v));
        if (v) begin
          checkOutput("rsp_tag_l1", 32'(ld_rsp_tag_l1), 32'(exp_tag_l1[cyc]));
          checkOutput("rsp_data_l1", 32'(ld_rsp_data_l1), 32'(exp_data_l1[cyc]));
          exp_tag_l1.delete(cyc); exp_data_l1.delete(cyc);
        end else begin
          checkOutput("idle_data_l1", 32'(ld_rsp_data_l1), 32'(0));
        end
        v = exp_tag_l3.exists(cyc);
        checkOutput("rsp_valid_l3", 32'(ld_rsp_valid_l3), 32'(v));
        if (v) begin
          checkOutput("rsp_tag_l3", 32'(ld_rsp_tag_l3), 32'(exp_tag_l3[cyc]));
          checkOutput("rsp_data_l3", 32'(ld_rsp_data_l3), 32'(exp_data_l3[cyc]));
          exp_tag_l3.delete(cyc); exp_data_l3.delete(cyc);
        end else begin
          checkOutput("idle_data_l3", 32'(ld_rsp_data_l3), 32'(0));
        end
        if (ld_rsp_valid_l1 === 1'b1) begin
          rsp_cnt_l1++; last_cyc_l1 = cyc; last_data_l1 = ld_rsp_data_l1; last_tag_l1 = ld_rsp_tag_l1;
        end
        if (ld_rsp_valid_l3 === 1'b1) begin
          rsp_cnt_l3++; last_cyc_l3 = cyc; last_data_l3 = ld_rsp_data_l3; last_tag_l3 = ld_rsp_tag_l3;
        end
      end
    end
  end

  task automatic applyStimulus(input bit lv, input logic [ADDR_W-1:0] la, input logic [TAG_W-1:0] lt,
                               input bit sv, input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd,
                               input logic [BE_W-1:0] sbe, input bit fl);
    @(negedge clk);
    #1;
    rst          = 1'b0;
    ld_req_valid = lv;
    ld_req_addr  = la;
    ld_req_tag   = lt;
    st_req_valid = sv;
    st_req_addr  = sa;
    st_req_data  = sd;
    st_req_be    = sbe;
    flush        = fl;
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #1;
    rst = 1'b1; ld_req_valid = 1'b0; st_req_valid = 1'b0; flush = 1'b0;
  endtask

  // Counts falling-edge samples with busy high, starting from the reset cycle.
  task automatic resetAndMeasure(output int cnt);
    pulseReset();
    @(negedge clk);
    cnt = (busy_l1 === 1'b1) ? 1 : 0;
    #1;
    rst = 1'b0;
    for (int guard = 0; guard < 64; guard++) begin
      @(negedge clk);
      if (busy_l1 !== 1'b1) break;
      cnt++;
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    int acc;
    int base1, base3;

    resetAndMeasure(busy_cnt);
    checkOutput("clear_len_first", 32'(busy_cnt), 32'd16);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 1'b1, 4'(i), 16'h8000 | 16'(i), 2'b11, 1'b0);
    resetAndMeasure(busy_cnt);
    checkOutput("clear_len_refill", 32'(busy_cnt), 32'd16);

    base1 = rsp_cnt_l1; base3 = rsp_cnt_l3;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 4'(i), 4'(i), 1'b0, '0, '0, '0, 1'b0);
    applyIdle(4);
    checkOutput("clear_loads_l1", 32'(rsp_cnt_l1 - base1), 32'd16);
    checkOutput("clear_loads_l3", 32'(rsp_cnt_l3 - base3), 32'd16);

    applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 16'hABCD, 2'b11, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 16'h1200, 2'b10, 1'b0);
    applyStimulus(1'b1, 4'd5, 4'd9, 1'b0, '0, '0, '0, 1'b0);
    applyIdle(4);
    checkOutput("be_data_l1", 32'(last_data_l1), 32'h12CD);
    checkOutput("be_tag_l1",  32'(last_tag_l1),  32'd9);
    checkOutput("be_data_l3", 32'(last_data_l3), 32'h12CD);
    checkOutput("be_tag_l3",  32'(last_tag_l3),  32'd9);

    applyStimulus(1'b1, 4'd3, 4'd7, 1'b1, 4'd3, 16'h5A5A, 2'b11, 1'b0);
    acc = cyc + 1;
    applyIdle(4);
    checkOutput("wf_data_l1", 32'(last_data_l1), 32'h5A5A);
    checkOutput("wf_tag_l1",  32'(last_tag_l1),  32'd7);
    checkOutput("wf_when_l1", 32'(last_cyc_l1),  32'(acc));
    checkOutput("wf_data_l3", 32'(last_data_l3), 32'h5A5A);
    checkOutput("wf_tag_l3",  32'(last_tag_l3),  32'd7);
    checkOutput("wf_when_l3", 32'(last_cyc_l3),  32'(acc + 2));

    base1 = rsp_cnt_l1; base3 = rsp_cnt_l3;
    applyStimulus(1'b1, 4'd1, 4'd1, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, 4'd2, 4'd2, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, 4'd3, 4'd3, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b1, 4'd5, 4'd4, 1'b0, '0, '0, '0, 1'b0);
    applyIdle(5);
    checkOutput("flush_count_l3", 32'(rsp_cnt_l3 - base3), 32'd1);
    checkOutput("flush_tag_l3",   32'(last_tag_l3),  32'd4);
    checkOutput("flush_data_l3",  32'(last_data_l3), 32'h12CD);
    checkOutput("flush_count_l1", 32'(rsp_cnt_l1 - base1), 32'd3);

    pulseReset();
    applyIdle(9);
    checkOutput("busy_mid_clear", 32'(busy_l1), 32'd1);
    resetAndMeasure(busy_cnt);
    checkOutput("clear_len_restart", 32'(busy_cnt), 32'd16);

    base1 = rsp_cnt_l1; base3 = rsp_cnt_l3;
    for (int i = 0; i < 64; i++)
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), 4'(i), 1'b1, 4'($urandom_range(0, 15)),
                    16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    applyIdle(4);
    checkOutput("stream_count_l1", 32'(rsp_cnt_l1 - base1), 32'd64);
    checkOutput("stream_count_l3", 32'(rsp_cnt_l3 - base3), 32'd64);

    for (int i = 0; i < 48; i++)
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)), 16'($urandom),
                    2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    applyIdle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
